// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - N-input truth-table evaluator with live path and exhaustive scan stream
module truth_table_scanner #(
    parameter int                N    = 3,
    parameter logic [(1<<N)-1:0] FUNC = 8'h54
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] live_in,
    output logic         live_s,
    input  logic         start,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_vec,
    output logic         out_s,
    output logic         done,
    output logic [N:0]   ones
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Terminal index is compared explicitly so the index never wraps back to 0.
    localparam logic [N-1:0] LAST = {N{1'b1}};

    state_t       state_q;
    logic         live_s_q;
    logic         busy_q;
    logic         out_valid_q;
    logic [N-1:0] index_q;
    logic         out_s_q;
    logic         done_q;
    logic [N:0]   ones_q;

    logic [N-1:0] index_d;
    logic         out_s_d;
    logic         xfer;

    assign index_d = index_q + 1'b1;
    assign out_s_d = FUNC[index_d];
    assign xfer    = out_valid_q & out_ready;

    // Live path: one-cycle registered table lookup, independent of the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_s_q <= 1'b0;
        end else begin
            live_s_q <= FUNC[live_in];
        end
    end

    // Scan engine: walks every input vector in order, holding each pair until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            index_q     <= '0;
            out_s_q     <= 1'b0;
            done_q      <= 1'b0;
            ones_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        index_q     <= '0;
                        out_s_q     <= FUNC[0];
                        ones_q      <= '0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        ones_q <= ones_q + {{N{1'b0}}, out_s_q};
                        if (index_q == LAST) begin
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            index_q <= index_d;
                            out_s_q <= out_s_d;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign live_s    = live_s_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_vec   = index_q;
    assign out_s     = out_s_q;
    assign done      = done_q;
    assign ones      = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - randomized self-checking bench for truth_table_scanner
module tb_truth_table_scanner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       out_ready;
    logic [7:0] live_in;
    int         sel;

    int n_tests;
    int n_fail;

    logic [15:0] ftab [0:2];
    int          nbits [0:2];

    // DUT 0: N=3 default function
    logic       start0, live0, busy0, valid0, s0, done0;
    logic [2:0] vec0;
    logic [3:0] ones0;
    // DUT 1: N=4 all-ones function
    logic       start1, live1, busy1, valid1, s1, done1;
    logic [3:0] vec1;
    logic [4:0] ones1;
    // DUT 2: N=1 identity function
    logic       start2, live2, busy2, valid2, s2, done2;
    logic [0:0] vec2;
    logic [1:0] ones2;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);
    assign start2 = start && (sel == 2);

    truth_table_scanner #(.N(3), .FUNC(8'h54)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .live_in(live_in[2:0]), .live_s(live0),
        .start(start0), .busy(busy0), .out_valid(valid0), .out_ready(out_ready),
        .out_vec(vec0), .out_s(s0), .done(done0), .ones(ones0)
    );

    truth_table_scanner #(.N(4), .FUNC(16'hFFFF)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .live_in(live_in[3:0]), .live_s(live1),
        .start(start1), .busy(busy1), .out_valid(valid1), .out_ready(out_ready),
        .out_vec(vec1), .out_s(s1), .done(done1), .ones(ones1)
    );

    truth_table_scanner #(.N(1), .FUNC(2'b10)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .live_in(live_in[0:0]), .live_s(live2),
        .start(start2), .busy(busy2), .out_valid(valid2), .out_ready(out_ready),
        .out_vec(vec2), .out_s(s2), .done(done2), .ones(ones2)
    );

    logic       m_live, m_busy, m_valid, m_s, m_done;
    logic [7:0] m_vec;
    logic [8:0] m_ones;

    always_comb begin
        m_live = live0; m_busy = busy0; m_valid = valid0; m_s = s0; m_done = done0;
        m_vec = {5'b0, vec0}; m_ones = {5'b0, ones0};
        case (sel)
            1: begin
                m_live = live1; m_busy = busy1; m_valid = valid1; m_s = s1; m_done = done1;
                m_vec = {4'b0, vec1}; m_ones = {4'b0, ones1};
            end
            2: begin
                m_live = live2; m_busy = busy2; m_valid = valid2; m_s = s2; m_done = done2;
                m_vec = {7'b0, vec2}; m_ones = {7'b0, ones2};
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {10'b0, m_valid, m_busy, m_done, m_s, m_live, m_vec, m_ones};
    endfunction

    // Registered live lookup: value applied now must appear one cycle later.
    task automatic live_run(input int cnt, input bit seq);
        logic [7:0] prev;
        int         lim;
        lim  = (1 << nbits[sel]) - 1;
        prev = 8'd0;
        for (int i = 0; i <= cnt; i++) begin
            @(negedge clk);
            if (i > 0) chk("live_s", {31'b0, m_live}, {31'b0, ftab[sel][prev]});
            live_in = seq ? 8'(i % (lim + 1)) : 8'($urandom_range(0, lim));
            prev    = live_in;
        end
    endtask

    // One scan: mode 0 ready=1, mode 1 ready pattern 1,0,0, mode 2 random ready.
    task automatic run_scan(input int mode, input bit inject, input int abort_at);
        int idx, xfers, dones, ones_m, total;
        bit post, finished, aborted;
        idx = 0; xfers = 0; dones = 0; ones_m = 0;
        post = 0; finished = 0; aborted = 0;
        total = 1 << nbits[sel];
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) chk("start_latency", {31'b0, m_valid}, 32'd1);
            if (post) begin
                chk("post_valid", {31'b0, m_valid}, 32'd0);
                chk("post_done", {31'b0, m_done}, 32'd0);
                finished = 1;
                break;
            end
            if (abort_at > 0 && xfers == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk("abort_zero", all_outs(), 32'd0);
                @(negedge clk);
                chk("abort_held", all_outs(), 32'd0);
                rst_n = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_nodone", {30'b0, m_done, m_valid}, 32'd0);
                end
                aborted = 1;
                break;
            end
            if (m_done) begin
                dones++;
                chk("done_ones", {23'b0, m_ones}, 32'(ones_m));
                chk("done_popcount", {23'b0, m_ones}, 32'($countones(ftab[sel])));
                chk("done_valid", {31'b0, m_valid}, 32'd0);
                chk("done_busy", {31'b0, m_busy}, 32'd0);
                post  = 1;
                start = inject;
            end else begin
                chk("valid", {31'b0, m_valid}, 32'd1);
                chk("busy", {31'b0, m_busy}, 32'd1);
                chk("vec", {24'b0, m_vec}, 32'(idx));
                chk("s", {31'b0, m_s}, {31'b0, ftab[sel][idx]});
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ((cyc % 3) == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                if (inject && cyc == 3) start = 1'b1;
                if (m_valid && out_ready) begin
                    ones_m += int'(ftab[sel][idx]);
                    idx++;
                    xfers++;
                end
            end
        end
        start = 1'b0;
        if (!aborted) begin
            chk("scan_finished", {31'b0, finished}, 32'd1);
            chk("xfers", 32'(xfers), 32'(total));
            chk("done_pulses", 32'(dones), 32'd1);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        ftab[0] = 16'h0054; ftab[1] = 16'hFFFF; ftab[2] = 16'h0002;
        nbits[0] = 3; nbits[1] = 4; nbits[2] = 1;
        sel = 0; start = 1'b0; out_ready = 1'b0; live_in = 8'd0;
        rst_n = 1'b1;

        // Asynchronous reset with no clock edge yet.
        #3 rst_n = 1'b0;
        #1 chk("reset_async", all_outs(), 32'd0);
        for (int d = 1; d < 3; d++) begin
            sel = d;
            #0 chk("reset_async_other", all_outs(), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", {30'b0, m_done, m_valid}, 32'd0);
        end

        // Live path: sequential then random vectors.
        live_run(8, 1'b1);
        live_run(16, 1'b0);

        // N=3 scans: full rate, pattern backpressure, random backpressure with stray starts.
        run_scan(0, 1'b0, 0);
        run_scan(1, 1'b0, 0);
        run_scan(2, 1'b1, 0);
        run_scan(0, 1'b0, 0);
        run_scan(0, 1'b0, 5);
        run_scan(0, 1'b0, 0);
        run_scan(2, 1'b0, 0);

        // N=4, all-ones table: count reaches 16 without wrapping.
        sel = 1;
        live_run(10, 1'b0);
        run_scan(0, 1'b0, 0);
        run_scan(2, 1'b0, 0);

        // N=1, identity table.
        sel = 2;
        live_run(6, 1'b0);
        run_scan(0, 1'b0, 0);
        run_scan(2, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Parametrised, clocked successor to the three-input combinational function blocks of guide 04. It evaluates an N-input Boolean function, held as a 2^N-bit truth-table parameter, in two ways:
- a registered live path, evaluated every cycle;
- an exhaustive scan engine that walks all 2^N input combinations in ascending order and streams each (inputs, result) pair over a valid/ready handshake.

At the end of a scan it reports the count of true minterms. It replaces hand-written testbench loops with a reusable truth-table generator.

## Interface
Parameters:
- N, 3, number of function inputs (1..8); input bit N-1 is the MSB (x for N=3).
- FUNC, 8'h54, truth table of width 2^N; bit i is the output for input vector i. The default encodes s = (x' . y')' . z'.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- live_in  input  N  input vector for the live path.
- live_s  output  1  registered FUNC[live_in].
- start  input  1  one-cycle request to begin a scan.
- busy  output  1  high from the cycle after start is accepted until the last pair is accepted.
- out_valid  output  1  out_vec and out_s hold a valid pair.
- out_ready  input  1  consumer accepts the pair when out_valid is also high.
- out_vec  output  N  current input combination.
- out_s  output  1  FUNC[out_vec].
- done  output  1  one-cycle pulse after the final pair is accepted.
- ones  output  N+1  count of accepted pairs with out_s=1 in the current or last scan.

## Operation
Reset (rst_n low, asynchronous):
- All outputs are 0: live_s, busy, out_valid, out_vec, out_s, done and ones.
- The state machine goes to IDLE.
- Releasing reset takes effect on the next clk edge.

Live path:
- live_s <= FUNC[live_in] on every edge.
- It is independent of the scan state.

State machine: states IDLE, SCAN and DONE.
- IDLE, start=1: load index 0, clear ones, set busy=1 and out_valid=1, go to SCAN.
- IDLE, start=0: stay in IDLE. out_valid=0. ones holds the result of the last scan.
- SCAN:
  - out_vec = index and out_s = FUNC[index], both from registers.
  - Transfer: out_valid & out_ready on a rising edge.
  - On transfer, ones increments when out_s=1.
  - On transfer with index < 2^N-1: index increments, out_valid stays high.
  - On transfer with index = 2^N-1: out_valid and busy go 0; go to DONE.
  - No transfer: all outputs hold stable. out_valid is never withdrawn before a transfer.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in SCAN and DONE; it is not queued.

Arithmetic:
- ones is N+1 bits wide, so its maximum 2^N never wraps.
- index is N bits wide. Its terminal value is detected explicitly and is never allowed to wrap to 0.

Reset mid-scan: the scan aborts immediately, all outputs go to 0, and no done pulse is issued.

## Timing
- live_s latency: 1 cycle.
- Scan latency: start sampled at edge k gives out_valid=1 with out_vec=0 after edge k.
- Throughput: one pair per cycle with out_ready held at 1.
- Scan length: the full scan occupies 2^N cycles of SCAN.
- done pulse: in the cycle after the last transfer.
- Back-to-back scans: the earliest accepted re-start is a start asserted during the DONE cycle's successor, i.e. when the machine is in IDLE.
- Fastest scan-to-scan gap: 2 cycles from the last transfer to the next first pair.
- ones: updates on the transfer edge and is valid alongside done.

## Test plan
- Reset: drive rst_n=0 mid-cycle with no clk edge -> all outputs read 0 at once. Release, then 3 idle cycles -> done=0 and out_valid=0.
- Default scan, N=3, FUNC=8'h54, out_ready=1: pulse start -> out_vec sequence 0..7 and out_s sequence 0,0,1,0,1,0,1,0 on consecutive cycles, then done pulses once with ones=3.
- Backpressure: toggle out_ready 1,0,0,1,... throughout the scan -> no pair is dropped or duplicated, out_vec/out_s stay stable while stalled, and ones ends at 3.
- start during SCAN, and start during DONE -> both ignored: exactly one done pulse and 8 transfers. A start in the following IDLE cycle launches a new scan.
- Reset at the 5th transfer -> outputs go 0 with no done pulse. A new scan afterwards runs cleanly with ones=3.
- Live path plus parameter sweep:
  - live_in 0..7 -> live_s follows one cycle later as 0,0,1,0,1,0,1,0.
  - N=4 with FUNC=16'hFFFF -> 16 pairs and ones=16 (no wrap).
  - N=1 with FUNC=2'b10 -> pairs (0,0),(1,1) and ones=1.
